// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin scheduler that shares one udp_tx engine
// among 4 channel FIFOs.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   req[3:0]   level request per channel (a whole packet is in the FIFO)
//   ch_dlen    payload length per channel, ch0 = [15:0] .. ch3 = [63:48]
//   grant      one-hot FIFO read select, held from ARB through GAP
//   eth_fs     start to udp_tx, high for all of SEND
//   eth_fd     done pulse from udp_tx (only looked at in SEND)
//   src_port   BASE_PORT + granted channel index (latched)
//   det_port   constant BASE_PORT
//   data_len   latched payload length; udp_len = data_len + 8 (wraps)
//   ch_done    one-cycle pulse on the channel that finished
//   ch_err     one-cycle pulse on bad length or watchdog expiry
//   busy       state is not IDLE
module udp_tx_arbiter #(
  parameter int unsigned GAP_CYC   = 12,
  parameter logic [15:0] BASE_PORT = 16'h1F90,
  parameter logic [15:0] MAX_DLEN  = 16'd1472,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] ch_dlen,
  output logic [3:0]  grant,
  output logic        eth_fs,
  input  logic        eth_fd,
  output logic [15:0] src_port,
  output logic [15:0] det_port,
  output logic [15:0] data_len,
  output logic [15:0] udp_len,
  output logic [3:0]  ch_done,
  output logic [3:0]  ch_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ARB, SEND, GAP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  rr_ptr;
  logic [1:0]  idx;
  logic        hit;
  logic [15:0] sel_len;
  logic        len_bad;
  logic [15:0] wd_cnt;
  logic [15:0] gap_cnt;
  logic        wd_hit;
  logic        gap_end;

  // Round-robin pick: walk offsets from high to low so the smallest
  // offset from rr_ptr that has a request is the one left standing.
  always_comb begin
    idx = rr_ptr;
    hit = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) begin
        idx = rr_ptr + 2'(k);
        hit = 1'b1;
      end
    end
  end

  assign sel_len = ch_dlen[{idx, 4'b0000} +: 16];
  assign len_bad = (sel_len == 16'd0) || (sel_len > MAX_DLEN);

  // wd_cnt is 0 on the first SEND cycle, so expiring at TIMEOUT-1 keeps
  // eth_fs high for exactly TIMEOUT cycles.
  assign wd_hit  = (wd_cnt == TIMEOUT - 16'd1);
  assign gap_end = (gap_cnt == 16'(GAP_CYC - 1));

  assign det_port = BASE_PORT;
  assign udp_len  = data_len + 16'd8;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|req) state_nxt = ARB;
      ARB: begin
        if (!hit)        state_nxt = IDLE;
        else if (len_bad) state_nxt = GAP;
        else             state_nxt = SEND;
      end
      // eth_fd has priority, but both leave for GAP anyway
      SEND: if (eth_fd || wd_hit) state_nxt = GAP;
      GAP:  if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= '0;
      eth_fs   <= 1'b0;
      ch_done  <= '0;
      ch_err   <= '0;
      src_port <= BASE_PORT;
      data_len <= '0;
      rr_ptr   <= '0;
      wd_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      ch_done <= '0;
      ch_err  <= '0;
      case (state)
        ARB: begin
          if (hit) begin
            grant    <= 4'(1) << idx;
            rr_ptr   <= idx + 2'd1;
            src_port <= BASE_PORT + {14'd0, idx};
            gap_cnt  <= '0;
            wd_cnt   <= '0;
            if (len_bad) begin
              ch_err <= 4'(1) << idx;
            end else begin
              data_len <= sel_len;
              eth_fs   <= 1'b1;
            end
          end
        end
        SEND: begin
          wd_cnt <= wd_cnt + 16'd1;
          if (eth_fd) begin
            ch_done <= grant;
            eth_fs  <= 1'b0;
          end else if (wd_hit) begin
            ch_err <= grant;
            eth_fs <= 1'b0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (gap_end) grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter (TIMEOUT shortened to 50 cycles).
module tb_udp_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] ch_dlen;
  logic [3:0]  grant;
  logic        eth_fs;
  logic        eth_fd;
  logic [15:0] src_port, det_port, data_len, udp_len;
  logic [3:0]  ch_done, ch_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  udp_tx_arbiter #(.GAP_CYC(12), .BASE_PORT(16'h1F90), .MAX_DLEN(16'd1472), .TIMEOUT(16'd50)) dut (
    .clk(clk), .rst(rst), .req(req), .ch_dlen(ch_dlen), .grant(grant),
    .eth_fs(eth_fs), .eth_fd(eth_fd), .src_port(src_port), .det_port(det_port),
    .data_len(data_len), .udp_len(udp_len), .ch_done(ch_done), .ch_err(ch_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; ch_dlen = '0; eth_fd = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic pulse_fd;
    eth_fd = 1'b1; tick; eth_fd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin tick; n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s idle timeout busy=%b", name, busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; ch_dlen = '0; eth_fd = 1'b0;
    tick; tick;
    checks++; if (grant !== 4'h0) begin errors++; $display("FAIL rst_grant got %h exp 0", grant); end
    checks++; if (eth_fs !== 1'b0) begin errors++; $display("FAIL rst_fs got %b exp 0", eth_fs); end
    checks++; if (ch_done !== 4'h0 || ch_err !== 4'h0) begin errors++; $display("FAIL rst_pulses got %h/%h exp 0/0", ch_done, ch_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (data_len !== 16'h0 || udp_len !== 16'h8) begin errors++; $display("FAIL rst_len got %h/%h exp 0000/0008", data_len, udp_len); end
    checks++; if (src_port !== 16'h1F90 || det_port !== 16'h1F90) begin errors++; $display("FAIL rst_ports got %h/%h exp 1f90/1f90", src_port, det_port); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    do_reset;
    ch_dlen = 64'h20; req = 4'b0001;
    tick;
    checks++; if (busy !== 1'b1 || eth_fs !== 1'b0) begin errors++; $display("FAIL single_arb busy/fs got %b/%b exp 1/0", busy, eth_fs); end
    tick;
    req = '0;
    checks++; if (eth_fs !== 1'b1) begin errors++; $display("FAIL single_fs got %b exp 1", eth_fs); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", grant); end
    checks++; if (src_port !== 16'h1F90) begin errors++; $display("FAIL single_src got %h exp 1f90", src_port); end
    checks++; if (data_len !== 16'h20 || udp_len !== 16'h28) begin errors++; $display("FAIL single_len got %h/%h exp 0020/0028", data_len, udp_len); end
    repeat (9) tick;
    checks++; if (eth_fs !== 1'b1) begin errors++; $display("FAIL single_fs_hold got %b exp 1", eth_fs); end
    pulse_fd;
    checks++; if (ch_done !== 4'b0001 || eth_fs !== 1'b0) begin errors++; $display("FAIL single_done got %b fs=%b exp 0001 fs=0", ch_done, eth_fs); end
    tick;
    checks++; if (ch_done !== 4'b0000) begin errors++; $display("FAIL single_done_once got %b exp 0000", ch_done); end
    repeat (10) tick;
    checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL single_gap_hold got %b busy=%b exp 0001 busy=1", grant, busy); end
    tick;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_gap_end got %b busy=%b exp 0000 busy=0", grant, busy); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    do_reset;
    ch_dlen = {4{16'h0020}}; req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      int n = 0;
      exp_g = 4'(1 << (p % 4));
      while (eth_fs !== 1'b1 && n < 40) begin tick; n++; end
      checks++; if (eth_fs !== 1'b1) begin errors++; $display("FAIL rr_fs_%0d never rose", p); end
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant_%0d got %b exp %b", p, grant, exp_g); end
      if (p > 0) begin
        checks++; if (n < 14) begin errors++; $display("FAIL rr_spacing_%0d got %0d exp >=14", p, n); end
      end
      repeat (4) tick;
      pulse_fd;
      checks++; if (ch_done !== exp_g) begin errors++; $display("FAIL rr_done_%0d got %b exp %b", p, ch_done, exp_g); end
    end
    req = '0;
    wait_idle("rr");
  endtask

  task automatic test_bad_len;
    logic [15:0] bad [2];
    logic        fs_seen;
    bad[0] = 16'd0; bad[1] = 16'd1473;
    do_reset;
    ch_dlen[47:32] = 16'h40; req = 4'b0100;
    tick; tick; req = '0;
    checks++; if (eth_fs !== 1'b1 || data_len !== 16'h40) begin errors++; $display("FAIL bad_pre got fs=%b len=%h exp 1/0040", eth_fs, data_len); end
    tick; pulse_fd;
    wait_idle("bad_pre");
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      ch_dlen[47:32] = bad[i]; req = 4'b0100;
      tick; tick; req = '0;
      checks++; if (ch_err !== 4'b0100 || eth_fs !== 1'b0) begin errors++; $display("FAIL bad_err_%0d got %b fs=%b exp 0100 fs=0", i, ch_err, eth_fs); end
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL bad_grant_%0d got %b exp 0100", i, grant); end
      checks++; if (data_len !== 16'h40 || udp_len !== 16'h48) begin errors++; $display("FAIL bad_len_%0d got %h/%h exp 0040/0048", i, data_len, udp_len); end
      tick;
      checks++; if (ch_err !== 4'b0000) begin errors++; $display("FAIL bad_err_once_%0d got %b exp 0000", i, ch_err); end
      fs_seen = eth_fs;
      while (busy !== 1'b0 && n < 40) begin tick; n++; fs_seen |= eth_fs; end
      checks++; if (fs_seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bad_nofs_%0d got fs=%b busy=%b exp 0/0", i, fs_seen, busy); end
    end
    ch_dlen[47:32] = 16'd1472; req = 4'b0100;
    tick; tick; req = '0;
    checks++; if (eth_fs !== 1'b1 || ch_err !== 4'b0) begin errors++; $display("FAIL max_ok got fs=%b err=%b exp 1/0000", eth_fs, ch_err); end
    checks++; if (data_len !== 16'd1472 || udp_len !== 16'd1480) begin errors++; $display("FAIL max_len got %h/%h exp 05c0/05c8", data_len, udp_len); end
    pulse_fd;
    wait_idle("max");
  endtask

  task automatic test_timeout;
    int n = 0;
    do_reset;
    ch_dlen[31:16] = 16'h20; req = 4'b0010;
    tick; tick; req = '0;
    while (eth_fs === 1'b1 && n < 100) begin n++; tick; end
    checks++; if (n != 50) begin errors++; $display("FAIL to_fs_cycles got %0d exp 50", n); end
    checks++; if (ch_err !== 4'b0010 || ch_done !== 4'b0) begin errors++; $display("FAIL to_err got %b done=%b exp 0010/0000", ch_err, ch_done); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick; end
    checks++; if (n != 12) begin errors++; $display("FAIL to_gap got %0d exp 12", n); end
  endtask

  task automatic test_fd_edge;
    do_reset;
    eth_fd = 1'b1; tick;
    checks++; if (busy !== 1'b0 || ch_done !== 4'b0 || eth_fs !== 1'b0) begin errors++; $display("FAIL fd_idle got busy=%b done=%b fs=%b exp 0/0000/0", busy, ch_done, eth_fs); end
    eth_fd = 1'b0; tick;
    checks++; if (busy !== 1'b0 || ch_done !== 4'b0 || ch_err !== 4'b0) begin errors++; $display("FAIL fd_idle2 got busy=%b done=%b err=%b exp 0/0000/0000", busy, ch_done, ch_err); end
    ch_dlen[31:16] = 16'h20; req = 4'b0010;
    tick; tick; req = '0;
    repeat (49) tick;
    checks++; if (eth_fs !== 1'b1) begin errors++; $display("FAIL coin_fs got %b exp 1", eth_fs); end
    pulse_fd;
    checks++; if (ch_done !== 4'b0010 || ch_err !== 4'b0000 || eth_fs !== 1'b0) begin errors++; $display("FAIL coin_done got done=%b err=%b fs=%b exp 0010/0000/0", ch_done, ch_err, eth_fs); end
    wait_idle("coin");
  endtask

  task automatic test_reset_mid;
    do_reset;
    ch_dlen = {4{16'h0020}}; req = 4'b0010;
    tick; tick; req = '0;
    checks++; if (grant !== 4'b0010 || eth_fs !== 1'b1) begin errors++; $display("FAIL mid1_pre got %b fs=%b exp 0010/1", grant, eth_fs); end
    tick;
    #3 rst = 1'b1;
    #1;
    checks++; if (eth_fs !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid1_async got fs=%b g=%b busy=%b exp 0/0000/0", eth_fs, grant, busy); end
    tick; rst = 1'b0;
    req = 4'b1111;
    tick; tick; req = '0;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid1_rrptr got %b exp 0001", grant); end
    pulse_fd;
    wait_idle("mid1");
    req = 4'b1000;
    tick; tick; req = '0;
    checks++; if (grant !== 4'b1000 || src_port !== 16'h1F93) begin errors++; $display("FAIL mid3_pre got %b src=%h exp 1000/1f93", grant, src_port); end
    repeat (3) tick;
    #3 rst = 1'b1;
    #1;
    checks++; if (eth_fs !== 1'b0 || grant !== 4'b0) begin errors++; $display("FAIL mid3_async got fs=%b g=%b exp 0/0000", eth_fs, grant); end
    checks++; if (data_len !== 16'h0 || udp_len !== 16'h8 || src_port !== 16'h1F90) begin errors++; $display("FAIL mid3_vals got %h/%h/%h exp 0000/0008/1f90", data_len, udp_len, src_port); end
    tick; rst = 1'b0;
    req = 4'b1000;
    tick; tick; req = '0;
    checks++; if (grant !== 4'b1000 || eth_fs !== 1'b1) begin errors++; $display("FAIL mid3_post got %b fs=%b exp 1000/1", grant, eth_fs); end
    pulse_fd;
    wait_idle("mid3");
  endtask

  initial begin
    rst = 1'b1; req = '0; ch_dlen = '0; eth_fd = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_bad_len;
    test_timeout;
    test_fd_edge;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Round-robin scheduler that shares one udp_tx engine among 4 packet sources (channel FIFOs).
- Grants one channel at a time and drives the engine's configuration: ports, payload length, UDP length.
- Sequences the engine over the fs/fd handshake, enforces an inter-packet gap and a watchdog timeout.
- Sits between the channel FIFO writers and the udp_tx/eth framing path.

Parameters:
- GAP_CYC, 12: idle cycles forced between packets (min 1).
- BASE_PORT, 16'h1F90: destination port; source port = BASE_PORT + channel index.
- MAX_DLEN, 16'd1472: largest legal payload length in bytes.
- TIMEOUT, 16'hFFFF: max SEND cycles waiting for eth_fd.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  4  level request per channel; a complete packet is ready in that channel's FIFO.
- ch_dlen  in  64  payload length per channel; ch0 = [15:0] ... ch3 = [63:48].
- grant  out  4  one-hot selected channel (FIFO read mux select); held from ARB through GAP.
- eth_fs  out  1  start to udp_tx; held high for the whole SEND state.
- eth_fd  in  1  done pulse from udp_tx.
- src_port  out  16  latched source port.
- det_port  out  16  destination port, always BASE_PORT.
- data_len  out  16  latched payload length.
- udp_len  out  16  data_len + 8, mod 2^16.
- ch_done  out  4  one-cycle pulse on the completed channel.
- ch_err  out  4  one-cycle pulse: rejected length or timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset values:
- grant=0, eth_fs=0, ch_done=0, ch_err=0, busy=0.
- data_len=0, udp_len=16'h0008, src_port=BASE_PORT, det_port=BASE_PORT.
- rr_ptr=0, counters=0, state=IDLE.

States:
- IDLE: if any req bit is set -> ARB.
- ARB (1 cycle):
  - Select the first set req bit scanning from rr_ptr upward, wrapping 3->0; call it idx.
  - Set grant = 1<<idx, rr_ptr = idx+1 mod 4, src_port = BASE_PORT+idx.
  - Latch data_len from ch_dlen[idx].
  - If ch_dlen[idx] is 0 or > MAX_DLEN: pulse ch_err[idx], data_len stays unchanged, -> GAP.
  - Otherwise -> SEND.
  - If req is all-zero on entry to ARB (request withdrawn): -> IDLE, nothing changes.
- SEND:
  - eth_fs=1 (registered, so high on the first SEND cycle).
  - Watchdog counter increments every cycle.
  - On eth_fd=1: pulse ch_done[idx] the next cycle, eth_fs=0, -> GAP.
  - If the counter reaches TIMEOUT with no eth_fd: pulse ch_err[idx], eth_fs=0, -> GAP.
  - If eth_fd and timeout occur in the same cycle, eth_fd wins (done, not error).
- GAP:
  - eth_fs=0, grant held.
  - Count GAP_CYC cycles, then clear grant -> IDLE.

Latency and handshake:
- Best case: req rise -> eth_fs high 2 cycles later (IDLE->ARB->SEND).
- Back-to-back packet spacing ≥ GAP_CYC+2 cycles after eth_fd.
- eth_fd is ignored outside SEND.
- req changes after ARB are ignored until the next ARB; dropping req mid-SEND does not abort the packet.
- ch_dlen is sampled only in ARB; later changes do not affect the packet in flight.

Arithmetic:
- udp_len is a 16-bit wrap (no overflow flag; unreachable for legal lengths).
- The watchdog is a 16-bit counter that clears on entering SEND.

Reset mid-operation:
- Asynchronous return to all reset values, including eth_fs dropping immediately.
- The engine must tolerate fs deasserting mid-packet.

Test Plan:
1. req=4'b0001, ch_dlen[15:0]=16'h20; eth_fd 10 cycles after eth_fs -> grant=0001, src_port=1F90, data_len=0020, udp_len=0028, ch_done[0] pulses once, grant clears after 12 gap cycles.
2. req=4'b1111 held, all lengths 16'h20, eth_fd after 5 cycles each time -> grant order 0,1,2,3,0; eth_fs low for ≥12 cycles between packets.
3. req=4'b0100, ch_dlen[47:32]=0, then 16'd1473 -> ch_err[2] pulses each time, eth_fs never rises, data_len unchanged.
4. req=4'b0010, eth_fd never asserted, TIMEOUT overridden to 16'd50 -> eth_fs high exactly 50 cycles, ch_err[1] pulses, state returns to IDLE after the gap.
5. eth_fd pulse while IDLE, and eth_fd coincident with the timeout cycle -> no action while IDLE; ch_done (not ch_err) in the coincident case.
6. rst asserted mid-SEND on ch3 -> eth_fs=0 and grant=0 immediately; after release with req=4'b1000 the first grant is ch3 with rr_ptr restarted from 0.
